// File: rtl/ram256x32_arbiter.sv
// rtl/ram256x32_arbiter.sv - two-master round-robin sequencer in front of a single-port 256x32 RAM
// Optional grant counters: define RAMARB_STATS_EN to add gnt_cnt0/gnt_cnt1.
module ram256x32_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
`ifdef RAMARB_STATS_EN
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1,
`endif
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_rw,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

    // The read stays in READ for RD_LAT+1 edges: RD_LAT for the RAM, one to capture Dout.
    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic       rd_port;
    logic [2:0] rd_cnt;

    logic       take;
    logic       win;
    logic       win_we;
    logic       rd_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = win_we ? WRITE : READ;
            WRITE:   state_nxt = IDLE;
            READ:    if (rd_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner: a lone requester wins; on a tie the master that did not win last time.
    always_comb begin
        take    = 1'b0;
        win     = 1'b0;
        win_we  = 1'b0;
        rd_done = 1'b0;
        if (state == IDLE && (req0 || req1)) begin
            take   = 1'b1;
            win    = (req0 && req1) ? ~last : req1;
            win_we = win ? we1 : we0;
        end
        if (state == READ && rd_cnt == LAT) begin
            rd_done = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last     <= 1'b1;
            rd_port  <= 1'b0;
            rd_cnt   <= 3'd0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_rw   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (take) begin
                ram_addr <= win ? addr1 : addr0;
                ram_din  <= win ? wdata1 : wdata0;
                ram_rw   <= win_we;
                gnt0     <= ~win;
                gnt1     <= win;
                last     <= win;
                rd_port  <= win;
                rd_cnt   <= 3'd0;
            end
            if (state == WRITE) begin
                ram_rw <= 1'b0;
            end
            if (state == READ) begin
                if (rd_done) begin
                    if (rd_port) begin
                        rdata1  <= ram_dout;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_dout;
                        rvalid0 <= 1'b1;
                    end
                end else begin
                    rd_cnt <= rd_cnt + 3'd1;
                end
            end
        end
    end

`ifdef RAMARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
        end else if (take) begin
            if (!win && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (win && gnt_cnt1 != 16'hFFFF)  gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram256x32_arbiter.sv
// tb/tb_ram256x32_arbiter.sv - scoreboard bench for ram256x32_arbiter
module tb_ram256x32_arbiter;
    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rw;
    logic [DW-1:0] ram_dout;
`ifdef RAMARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

    always #5 clk = ~clk;

    ram256x32_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
`ifdef RAMARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_rw(ram_rw), .ram_dout(ram_dout)
    );

    // RAM behavioural model with RD_LAT-edge read latency
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_din;
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout = pipe[RD_LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] shadow [256];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            rv0_cnt = 0;
    int            rv1_cnt = 0;
    logic          prev_rw = 1'b0;

    always @(negedge clk) begin
        if (rvalid0) begin
            rv0_cnt++;
            if (exp_q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
            else check("rdata0", rdata0, exp_q0.pop_front());
        end
        if (rvalid1) begin
            rv1_cnt++;
            if (exp_q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
            else check("rdata1", rdata1, exp_q1.pop_front());
        end
        if (gnt0 && gnt1) check("dual_gnt", 32'd1, 32'd0);
        if (ram_rw && prev_rw) check("rw_pulse_width", 32'd2, 32'd1);
        prev_rw = ram_rw;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic access(input int m, input logic w, input logic [7:0] a,
                          input logic [31:0] d, input bit track);
        int n;
        @(negedge clk);
        if (m == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m == 0 ? gnt0 : gnt1) && n < 50);
        if (n >= 50) check("gnt_timeout", 32'd0, 32'd1);
        if (m == 0) req0 = 1'b0; else req1 = 1'b0;
        if (w) shadow[a] = d;
        else if (track) begin
            if (m == 0) exp_q0.push_back(shadow[a]);
            else        exp_q1.push_back(shadow[a]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int            seq [$];
        int            n;
        int            lat;
        int            rv0_before;
        int            quiet;
        logic [31:0]   d;

        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 32'h1111_0001;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02; wdata1 = 32'h2222_0002;

        // 1. reset with both requesting
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt0", gnt0, 1'b0);
            check("rst_gnt1", gnt1, 1'b0);
            check("rst_rw", ram_rw, 1'b0);
            check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        end
        check("rst_rdata0", rdata0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_gnt0", gnt0, 1'b1);
        check("first_gnt1", gnt1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        shadow[8'h01] = wdata0;
        repeat (2) @(negedge clk);

        // 2. single write then read with latency
        access(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
        check("wr_rw_high", ram_rw, 1'b1);
        check("wr_addr", ram_addr, 8'h10);
        @(negedge clk);
        check("wr_rw_low", ram_rw, 1'b0);
        access(0, 1'b0, 8'h10, 32'h0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rvalid0 && lat < 20);
        check("rd_latency", lat, RD_LAT + 1);
        check("rd_data_direct", rdata0, 32'hDEADBEEF);
        drain();

        // 3. contention: strict alternation
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 32'hA0A0_0020;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 32'hB1B1_0021;
        n = 0;
        while (seq.size() < 6 && n < 100) begin
            @(negedge clk);
            n++;
            if (gnt0) seq.push_back(0);
            if (gnt1) seq.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        shadow[8'h20] = wdata0;
        shadow[8'h21] = wdata1;
        check("rr_count", seq.size(), 6);
        for (int i = 0; i < seq.size(); i++) check("rr_order", seq[i], i % 2);
        repeat (2) @(negedge clk);
`ifdef RAMARB_STATS_EN
        check("stats_cnt0", gnt_cnt0, 16'd3);
        check("stats_cnt1", gnt_cnt1, 16'd3);
        @(negedge clk);
        force dut.gnt_cnt0 = 16'hFFFE;
        @(negedge clk);
        release dut.gnt_cnt0;
        for (int i = 0; i < 3; i++) access(0, 1'b1, 8'h30, 32'h0, 1'b0);
        shadow[8'h30] = 32'h0;
        @(negedge clk);
        check("stats_sat", gnt_cnt0, 16'hFFFF);
`endif
        access(1, 1'b0, 8'h20, 32'h0, 1'b1);
        access(0, 1'b0, 8'h21, 32'h0, 1'b1);
        drain();

        // 4. fill and readback through master 1
        rv0_before = rv0_cnt;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            access(1, 1'b1, 8'(i), d, 1'b0);
        end
        for (int i = 0; i < 256; i++) access(1, 1'b0, 8'(i), 32'h0, 1'b1);
        access(1, 1'b0, 8'hFF, 32'h0, 1'b1);
        access(1, 1'b0, 8'h00, 32'h0, 1'b1);
        drain();
        check("fill_rvalid0_quiet", rv0_cnt, rv0_before);
        check("fill_rvalid1_cnt", rv1_cnt >= 258, 1'b1);

        // 5. reset during an outstanding read
        access(0, 1'b0, 8'h10, 32'h0, 1'b0);
        rst_n = 1'b0;
        quiet = 0;
        repeat (2) begin
            @(negedge clk);
            if (rvalid0) quiet++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rvalid0) quiet++;
        end
        check("midrst_rvalid0", quiet, 0);
        check("midrst_rdata0", rdata0, 32'h0);
        access(0, 1'b0, 8'h10, 32'h0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
